spi_slave_register_file: RTL and testbench
==========================================

SPI_SLAVE_REGISTER_FILE -- requirements
Module: spi_slave_register_file

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_WIDTH, 16, data word width.
- ADDRESS_WIDTH, 15, address field width on the serial frame.
- DEPTH, 256, register count; power of two, at least 2; AW_INT = log2(DEPTH).
- CLOCK_POLARITY, 0, serial_clock idle level.
- CLOCK_PHASE, 0, 0 = sample on leading edge, 1 = sample on trailing edge.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- serial_clock  in  1  SPI clock from the master; asynchronous.
- chip_select  in  1  active-low frame select; asynchronous.
- serial_in  in  1  MOSI; asynchronous.
- serial_out  out  1  MISO.
- local_write_enable  in  1  fabric-side write strobe.
- local_address  in  AW_INT  fabric-side address.
- local_write_data  in  DATA_WIDTH  fabric-side write data.
- local_read_data  out  DATA_WIDTH  registered read of local_address.
- spi_write_valid  out  1  one-cycle pulse per completed SPI write word.
- spi_write_address  out  AW_INT  address of that word.
- busy  out  1  high while a frame is in progress.

Function
REQ-003 serial_clock, chip_select and serial_in SHALL each pass through a 2-flop synchroniser; all edge detection SHALL use the synchronised signals.
REQ-004 The leading edge SHALL be the transition away from the CLOCK_POLARITY level, and the trailing edge the transition back to it.
REQ-005 The sample edge SHALL be the leading edge when CLOCK_PHASE=0 and the trailing edge when CLOCK_PHASE=1; the shift edge is the other edge.
REQ-006 Correct operation SHALL be required only when the serial_clock half-period is at least 4 clock cycles.
REQ-007 Frame format, MSB first:
- 1 read/write bit (1 = read, 0 = write).
- ADDRESS_WIDTH address bits.
- One or more DATA_WIDTH data words (burst).
REQ-008 The state machine SHALL have the states IDLE, COMMAND, DATA and WAIT_DESELECT.
REQ-009 In IDLE, a synchronised chip_select falling edge SHALL enter COMMAND and clear the bit counter; busy SHALL go high on that cycle.
REQ-010 COMMAND SHALL sample 1+ADDRESS_WIDTH bits, then enter DATA with word_address = address[AW_INT-1:0]; upper address bits SHALL be ignored.
REQ-011 On a read, mem[word_address] SHALL be loaded into the transmit shift register within 2 clocks of the last command sample.
REQ-012 On a read, the transmit MSB SHALL drive serial_out before the next leading edge; later bits SHALL change only on shift edges.
REQ-013 On a write, after DATA_WIDTH samples, mem[word_address] SHALL be updated and spi_write_valid pulsed for 1 cycle with spi_write_address = word_address.
REQ-014 After each completed data word, word_address SHALL increment modulo DEPTH (DEPTH-1 wraps to 0); a read SHALL reload the shift register from the new address.
REQ-015 A chip_select rising edge in COMMAND or DATA SHALL return the block to IDLE; a partial word SHALL be discarded with no write and no pulse.
REQ-016 serial_out SHALL be 0 whenever the block is not in DATA on a read frame.
REQ-017 local_read_data SHALL equal mem[local_address] one cycle after local_address is presented.
REQ-018 A local write SHALL take effect on the next clock edge.
REQ-019 When a local write and an SPI write hit the same address in the same cycle, the local write SHALL win; spi_write_valid SHALL still pulse.
REQ-020 busy SHALL be high in COMMAND and DATA and low in IDLE and WAIT_DESELECT.

Reset
REQ-021 reset SHALL force the following on the next clock edge:
- state to IDLE.
- serial_out, busy, spi_write_valid, spi_write_address and local_read_data to 0.
- all DEPTH registers to 0.
- the shift and bit counters to 0.
REQ-022 If chip_select is low when reset deasserts, or reset occurs mid-frame, the block SHALL enter WAIT_DESELECT and ignore all serial activity until chip_select goes high; it then enters IDLE.

Verification
REQ-023 Single write, mode 0: frame rw=0, addr=0x0011, data=0xA5C3 -> one spi_write_valid pulse with address 0x11; local read of 0x11 returns 0xA5C3.
REQ-024 Single read: local write 0xBEEF to 0x22, then SPI read at 0x0022 -> master captures 0xBEEF; serial_out is 0 after chip_select rises.
REQ-025 Burst write with wrap, DEPTH=256: write starting at 0x00FE with 3 words 0x1111, 0x2222, 0x3333 -> registers 0xFE, 0xFF and 0x00 are written and 3 pulses are seen.
REQ-026 Abort: chip_select rises after 7 data bits of a write to 0x05 -> register 0x05 unchanged, no pulse, busy low within 4 clocks.
REQ-027 Modes: repeat REQ-023 and REQ-024 for all four CLOCK_POLARITY/CLOCK_PHASE pairs with the serial_clock half-period at 4 clocks -> identical results.
REQ-028 Reset mid-frame, then the remainder of the frame -> no writes occur; the next full frame completes correctly.

Source files
------------

// File: rtl/spi_slave_register_file.sv
`timescale 1ns / 1ps
// SPI slave exposing a DEPTH-entry register file over a serial frame, plus a
// fabric-side local port with one-cycle registered reads.
module spi_slave_register_file #(
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned ADDRESS_WIDTH  = 15,
   parameter int unsigned DEPTH          = 256,
   parameter bit          CLOCK_POLARITY = 1'b0,
   parameter bit          CLOCK_PHASE    = 1'b0,
   localparam int unsigned AW_INT        = $clog2(DEPTH)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  serial_clock,
   input  logic                  chip_select,
   input  logic                  serial_in,
   output logic                  serial_out,
   input  logic                  local_write_enable,
   input  logic [AW_INT-1:0]     local_address,
   input  logic [DATA_WIDTH-1:0] local_write_data,
   output logic [DATA_WIDTH-1:0] local_read_data,
   output logic                  spi_write_valid,
   output logic [AW_INT-1:0]     spi_write_address,
   output logic                  busy
);

   localparam int unsigned CMD_BITS = ADDRESS_WIDTH + 1;
   localparam int unsigned CNT_MAX  = (CMD_BITS > DATA_WIDTH) ? CMD_BITS : DATA_WIDTH;
   localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(CMD_BITS - 1);
   localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_WIDTH - 1);
   localparam logic [AW_INT-1:0] ADDR_ONE  = AW_INT'(1);

   typedef enum logic [1:0] {
      StIdle,
      StCommand,
      StData,
      StWaitDeselect
   } state_e;

   state_e state_q, state_d;

   logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
   logic cs_meta_q, cs_sync_q, cs_prev_q;
   logic mosi_meta_q, mosi_sync_q;

   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [ADDRESS_WIDTH-1:0] cmd_q, cmd_d;
   logic [CMD_BITS-1:0]      cmd_next;
   logic                     is_read_q, is_read_d;
   logic [AW_INT-1:0]        word_addr_q, word_addr_d, addr_inc;
   logic [DATA_WIDTH-2:0]    rx_q, rx_d;
   logic [DATA_WIDTH-1:0]    rx_next;
   logic [DATA_WIDTH-1:0]    tx_q, tx_d;
   logic                     spi_we;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic lead_edge, trail_edge, sample_edge, shift_edge, cs_fall, cs_rise;

   // Synchronisers are left unreset so that a chip_select already low at reset
   // release is seen as a level, not as a fresh falling edge.
   always_ff @(posedge clock) begin
      sclk_meta_q <= serial_clock;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      cs_meta_q   <= chip_select;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      mosi_meta_q <= serial_in;
      mosi_sync_q <= mosi_meta_q;
   end

   assign lead_edge   = (sclk_prev_q == CLOCK_POLARITY) && (sclk_sync_q != CLOCK_POLARITY);
   assign trail_edge  = (sclk_prev_q != CLOCK_POLARITY) && (sclk_sync_q == CLOCK_POLARITY);
   assign sample_edge = CLOCK_PHASE ? trail_edge : lead_edge;
   assign shift_edge  = CLOCK_PHASE ? lead_edge : trail_edge;
   assign cs_fall     = cs_prev_q & ~cs_sync_q;
   assign cs_rise     = ~cs_prev_q & cs_sync_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmd_d       = cmd_q;
      is_read_d   = is_read_q;
      word_addr_d = word_addr_q;
      rx_d        = rx_q;
      tx_d        = tx_q;
      spi_we      = 1'b0;
      cmd_next    = {cmd_q, mosi_sync_q};
      rx_next     = {rx_q, mosi_sync_q};
      addr_inc    = word_addr_q + ADDR_ONE;

      unique case (state_q)
         StIdle: begin
            if (cs_fall) begin
               state_d = StCommand;
               cnt_d   = '0;
            end else if (!cs_sync_q) begin
               state_d = StWaitDeselect;
            end
         end
         StCommand: begin
            if (cs_rise) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (sample_edge) begin
               cmd_d = cmd_next[ADDRESS_WIDTH-1:0];
               if (cnt_q == CMD_LAST) begin
                  state_d     = StData;
                  cnt_d       = '0;
                  is_read_d   = cmd_next[ADDRESS_WIDTH];
                  word_addr_d = cmd_next[AW_INT-1:0];
                  tx_d        = mem_q[cmd_next[AW_INT-1:0]];
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         StData: begin
            if (cs_rise) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (sample_edge) begin
               rx_d = rx_next[DATA_WIDTH-2:0];
               if (cnt_q == DATA_LAST) begin
                  cnt_d       = '0;
                  spi_we      = ~is_read_q;
                  word_addr_d = addr_inc;
                  tx_d        = mem_q[addr_inc];
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end else if (shift_edge && (cnt_q != '0)) begin
               // A freshly loaded word keeps its MSB until it has been sampled once.
               tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
            end
         end
         StWaitDeselect: begin
            if (cs_sync_q) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q           <= StIdle;
         cnt_q             <= '0;
         cmd_q             <= '0;
         is_read_q         <= 1'b0;
         word_addr_q       <= '0;
         rx_q              <= '0;
         tx_q              <= '0;
         spi_write_valid   <= 1'b0;
         spi_write_address <= '0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         cmd_q           <= cmd_d;
         is_read_q       <= is_read_d;
         word_addr_q     <= word_addr_d;
         rx_q            <= rx_d;
         tx_q            <= tx_d;
         spi_write_valid <= spi_we;
         if (spi_we) begin
            spi_write_address <= word_addr_q;
         end
      end
   end

   // The local write is issued last so it wins an address collision.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         local_read_data <= '0;
      end else begin
         if (spi_we) begin
            mem_q[word_addr_q] <= rx_next;
         end
         if (local_write_enable) begin
            mem_q[local_address] <= local_write_data;
         end
         local_read_data <= mem_q[local_address];
      end
   end

   assign serial_out = (state_q == StData) & is_read_q & tx_q[DATA_WIDTH-1];
   assign busy       = (state_q == StCommand) || (state_q == StData);

endmodule

// File: tb/tb_spi_slave_register_file.sv
`timescale 1ns / 1ps
// Drives four instances (one per SPI mode) from a bit-level master and checks
// them against an array model of the register file.
module tb_spi_slave_register_file;

   localparam int DW    = 16;
   localparam int AWS   = 15;
   localparam int DEPTH = 256;
   localparam int AWI   = 8;
   localparam int CMD   = AWS + 1;
   localparam int H     = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic [3:0] sclk = 4'b1100;
   logic [3:0] cs_n = 4'b1111;
   logic [3:0] mosi = 4'b0000;
   wire  [3:0] miso, busy, wvalid;
   wire  [AWI-1:0] waddr [4];
   wire  [DW-1:0]  lrd [4];
   logic           lwe = 1'b0;
   logic [AWI-1:0] laddr = '0;
   logic [DW-1:0]  lwdata = '0;

   spi_slave_register_file #(.CLOCK_POLARITY(1'b0), .CLOCK_PHASE(1'b0)) u_dut0 (
      .clock(clock), .reset(reset), .serial_clock(sclk[0]), .chip_select(cs_n[0]),
      .serial_in(mosi[0]), .serial_out(miso[0]), .local_write_enable(lwe),
      .local_address(laddr), .local_write_data(lwdata), .local_read_data(lrd[0]),
      .spi_write_valid(wvalid[0]), .spi_write_address(waddr[0]), .busy(busy[0]));
   spi_slave_register_file #(.CLOCK_POLARITY(1'b0), .CLOCK_PHASE(1'b1)) u_dut1 (
      .clock(clock), .reset(reset), .serial_clock(sclk[1]), .chip_select(cs_n[1]),
      .serial_in(mosi[1]), .serial_out(miso[1]), .local_write_enable(lwe),
      .local_address(laddr), .local_write_data(lwdata), .local_read_data(lrd[1]),
      .spi_write_valid(wvalid[1]), .spi_write_address(waddr[1]), .busy(busy[1]));
   spi_slave_register_file #(.CLOCK_POLARITY(1'b1), .CLOCK_PHASE(1'b0)) u_dut2 (
      .clock(clock), .reset(reset), .serial_clock(sclk[2]), .chip_select(cs_n[2]),
      .serial_in(mosi[2]), .serial_out(miso[2]), .local_write_enable(lwe),
      .local_address(laddr), .local_write_data(lwdata), .local_read_data(lrd[2]),
      .spi_write_valid(wvalid[2]), .spi_write_address(waddr[2]), .busy(busy[2]));
   spi_slave_register_file #(.CLOCK_POLARITY(1'b1), .CLOCK_PHASE(1'b1)) u_dut3 (
      .clock(clock), .reset(reset), .serial_clock(sclk[3]), .chip_select(cs_n[3]),
      .serial_in(mosi[3]), .serial_out(miso[3]), .local_write_enable(lwe),
      .local_address(laddr), .local_write_data(lwdata), .local_read_data(lrd[3]),
      .spi_write_valid(wvalid[3]), .spi_write_address(waddr[3]), .busy(busy[3]));

   logic [DW-1:0] model [4][DEPTH];
   logic [DW-1:0] wq[$];
   bit            tx_bits[$];
   bit            rx_bits[$];
   int unsigned   seen[$];
   int            cur_mode = 0;
   int            stray = 0;
   int            errors = 0;
   int            checks = 0;

   always @(negedge clock) begin
      for (int m = 0; m < 4; m++) begin
         if (wvalid[m] === 1'b1) begin
            if (m == cur_mode) seen.push_back(int'(waddr[m]));
            else stray++;
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   function automatic bit cpol(input int m);
      return m[1];
   endfunction

   function automatic bit cpha(input int m);
      return m[0];
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic clear_model();
      for (int m = 0; m < 4; m++)
         for (int a = 0; a < DEPTH; a++) model[m][a] = '0;
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      reset = 1'b1;
      clear_model();
      wait_clk(3);
      reset = 1'b0;
   endtask

   task automatic local_write(input logic [AWI-1:0] a, input logic [DW-1:0] d);
      @(negedge clock);
      lwe = 1'b1; laddr = a; lwdata = d;
      @(negedge clock);
      lwe = 1'b0;
      for (int m = 0; m < 4; m++) model[m][a] = d;
   endtask

   task automatic check_local(input int m, input logic [AWI-1:0] a, input string tag);
      @(negedge clock);
      laddr = a;
      @(negedge clock);
      checks++;
      if (lrd[m] !== model[m][a]) begin
         errors++;
         $display("FAIL %s mode%0d local read @%02h: got %h want %h", tag, m, a, lrd[m],
                  model[m][a]);
      end
   endtask

   task automatic build_frame(input bit rw, input logic [AWS-1:0] addr);
      tx_bits.delete();
      tx_bits.push_back(rw);
      for (int i = AWS - 1; i >= 0; i--) tx_bits.push_back(addr[i]);
      for (int k = 0; k < wq.size(); k++)
         for (int j = DW - 1; j >= 0; j--) tx_bits.push_back(rw ? 1'b0 : wq[k][j]);
   endtask

   // Master side: sample MISO on the same edge the slave samples MOSI.
   task automatic run_frame(input int m, input int reset_at, input string tag);
      bit p  = cpol(m);
      bit ph = cpha(m);
      int n  = tx_bits.size();
      rx_bits.delete();
      cur_mode = m;
      cs_n[m] = 1'b0;
      if (!ph) mosi[m] = tx_bits[0];
      wait_clk(H);
      checks++;
      if (busy[m] !== 1'b1) begin
         errors++;
         $display("FAIL %s mode%0d busy during frame: got %b want 1", tag, m, busy[m]);
      end
      for (int i = 0; i < n; i++) begin
         if (i == reset_at) pulse_reset();
         if (!ph) begin
            rx_bits.push_back(miso[m]);
            sclk[m] = ~p;
            wait_clk(H);
            sclk[m] = p;
            if (i + 1 < n) mosi[m] = tx_bits[i+1];
            wait_clk(H);
         end else begin
            sclk[m] = ~p;
            mosi[m] = tx_bits[i];
            wait_clk(H);
            rx_bits.push_back(miso[m]);
            sclk[m] = p;
            wait_clk(H);
         end
      end
      cs_n[m] = 1'b1;
      mosi[m] = 1'b0;
      wait_clk(4);
      checks++;
      if (busy[m] !== 1'b0 || miso[m] !== 1'b0) begin
         errors++;
         $display("FAIL %s mode%0d after deselect: busy=%b miso=%b want 0/0", tag, m,
                  busy[m], miso[m]);
      end
      wait_clk(4);
   endtask

   task automatic spi_write(input int m, input logic [AWS-1:0] addr, input string tag);
      int unsigned base = int'(addr[AWI-1:0]);
      build_frame(1'b0, addr);
      seen.delete();
      run_frame(m, -1, tag);
      for (int k = 0; k < wq.size(); k++) model[m][(base + k) % DEPTH] = wq[k];
      checks++;
      if (seen.size() != wq.size()) begin
         errors++;
         $display("FAIL %s mode%0d pulse count: got %0d want %0d", tag, m, seen.size(),
                  wq.size());
      end else begin
         for (int k = 0; k < wq.size(); k++) begin
            checks++;
            if (seen[k] != (base + k) % DEPTH) begin
               errors++;
               $display("FAIL %s mode%0d pulse %0d address: got %02h want %02h", tag, m, k,
                        seen[k], (base + k) % DEPTH);
            end
         end
      end
   endtask

   task automatic spi_read(input int m, input logic [AWS-1:0] addr, input int n,
                           input string tag);
      int unsigned   base = int'(addr[AWI-1:0]);
      logic [DW-1:0] word;
      int            ones = 0;
      wq.delete();
      for (int k = 0; k < n; k++) wq.push_back('0);
      build_frame(1'b1, addr);
      run_frame(m, -1, tag);
      for (int i = 0; i < CMD; i++) ones += int'(rx_bits[i]);
      checks++;
      if (ones != 0) begin
         errors++;
         $display("FAIL %s mode%0d miso during command: got %0d ones want 0", tag, m, ones);
      end
      for (int k = 0; k < n; k++) begin
         word = '0;
         for (int j = 0; j < DW; j++) word = {word[DW-2:0], rx_bits[CMD + k*DW + j]};
         checks++;
         if (word !== model[m][(base + k) % DEPTH]) begin
            errors++;
            $display("FAIL %s mode%0d read word %0d: got %h want %h", tag, m, k, word,
                     model[m][(base + k) % DEPTH]);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      wait_clk(5);
      reset = 1'b0;
      clear_model();
      wait_clk(2);
      checks++;
      if (busy !== 4'b0 || miso !== 4'b0 || wvalid !== 4'b0) begin
         errors++;
         $display("FAIL reset outputs: busy=%b miso=%b valid=%b want all 0", busy, miso, wvalid);
      end
      for (int m = 0; m < 4; m++) begin
         checks++;
         if (lrd[m] !== '0 || waddr[m] !== '0) begin
            errors++;
            $display("FAIL reset mode%0d data/address: got %h/%h want 0/0", m, lrd[m], waddr[m]);
         end
      end
      local_write(8'h40, 16'h1234);
      check_local(0, 8'h40, "local_write");
      pulse_reset();
      wait_clk(2);
      for (int m = 0; m < 4; m++) check_local(m, 8'h40, "reset_clears_mem");
   endtask

   task automatic test_single_write(input int m);
      wq = '{16'hA5C3};
      spi_write(m, 15'h0011, "single_write");
      check_local(m, 8'h11, "single_write");
   endtask

   task automatic test_single_read(input int m);
      local_write(8'h22, 16'hBEEF);
      spi_read(m, 15'h0022, 1, "single_read");
   endtask

   task automatic test_burst_wrap(input int m);
      wq = '{16'h1111, 16'h2222, 16'h3333};
      spi_write(m, 15'h00FE, "burst_wrap");
      check_local(m, 8'hFE, "burst_wrap");
      check_local(m, 8'hFF, "burst_wrap");
      check_local(m, 8'h00, "burst_wrap");
      spi_read(m, 15'h00FF, 2, "burst_read_wrap");
   endtask

   task automatic test_abort(input int m);
      local_write(8'h05, 16'($urandom));
      wq = '{16'($urandom)};
      build_frame(1'b0, 15'h0005);
      while (tx_bits.size() > CMD + 7) void'(tx_bits.pop_back());
      seen.delete();
      run_frame(m, -1, "abort");
      checks++;
      if (seen.size() != 0) begin
         errors++;
         $display("FAIL abort mode%0d pulses: got %0d want 0", m, seen.size());
      end
      check_local(m, 8'h05, "abort");
   endtask

   task automatic test_reset_mid_frame(input int m);
      wq = '{16'($urandom), 16'($urandom)};
      build_frame(1'b0, 15'h0033);
      seen.delete();
      run_frame(m, CMD + 5, "reset_mid_frame");
      checks++;
      if (seen.size() != 0) begin
         errors++;
         $display("FAIL reset_mid_frame mode%0d pulses: got %0d want 0", m, seen.size());
      end
      check_local(m, 8'h33, "reset_mid_frame");
      check_local(m, 8'h34, "reset_mid_frame");
      wq = '{16'($urandom)};
      spi_write(m, 15'h0033, "after_reset_write");
      check_local(m, 8'h33, "after_reset_write");
   endtask

   task automatic test_random(input int m);
      for (int t = 0; t < 5; t++) begin
         logic [AWS-1:0] addr = AWS'($urandom);
         int             n    = int'($urandom_range(1, 3));
         if ($urandom_range(0, 2) == 0) local_write(AWI'($urandom), 16'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            spi_read(m, addr, n, "random_read");
         end else begin
            wq.delete();
            for (int k = 0; k < n; k++) wq.push_back(16'($urandom));
            spi_write(m, addr, "random_write");
         end
      end
   endtask

   task automatic test_sweep();
      @(negedge clock);
      for (int a = 0; a < DEPTH; a++) begin
         laddr = AWI'(a);
         @(negedge clock);
         for (int m = 0; m < 4; m++) begin
            checks++;
            if (lrd[m] !== model[m][a]) begin
               errors++;
               $display("FAIL sweep mode%0d @%02h: got %h want %h", m, a, lrd[m], model[m][a]);
            end
         end
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL stray pulses on idle instances: got %0d want 0", stray);
      end
   endtask

   initial begin
      test_reset();
      for (int m = 0; m < 4; m++) begin
         test_single_write(m);
         test_single_read(m);
         test_burst_wrap(m);
         test_abort(m);
         test_reset_mid_frame(m);
         test_random(m);
      end
      test_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
